// File: rtl/hazard_scoreboard_unit.sv
// Scoreboard-based stall / forward / flush control for an in-order pipeline with DEPTH post-ID stages.
// Optional performance counters are compiled in with `define HDU_PERF_CNT_EN.
module hazard_scoreboard_unit #(
  parameter int DEPTH      = 3,
  parameter int REG_AW     = 5,
  parameter int STORE_NEED = 1,
  parameter int SW         = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_ID,
  input  logic              branch_ID,
  input  logic [REG_AW-1:0] rs1_ID,
  input  logic [REG_AW-1:0] rs2_ID,
  input  logic              rs1use_ID,
  input  logic              rs2use_ID,
  input  logic              rs2late_ID,
  input  logic [REG_AW-1:0] rd_ID,
  input  logic              wen_ID,
  input  logic [SW-1:0]     rdy_stage_ID,
  output logic              PC_EN_IF,
  output logic              reg_FD_EN,
  output logic              reg_FD_flush,
  output logic              reg_DE_flush,
  output logic [SW-1:0]     fwd_sel_A,
  output logic [SW-1:0]     fwd_sel_B,
  output logic [SW-1:0]     fwd_ls_sel,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
);

  logic              v_reg   [1:DEPTH];
  logic [REG_AW-1:0] rd_reg  [1:DEPTH];
  logic              wen_reg [1:DEPTH];
  logic [SW-1:0]     rdy_reg [1:DEPTH];
  logic [SW-1:0]     ls_reg  [1:DEPTH];

  logic stall;
  logic issue;

  // One lookup per source operand; index 0 = rs1, index 1 = rs2.
  for (genvar gi = 0; gi < 2; gi++) begin : src_gen
    logic [REG_AW-1:0] src;
    logic              used;
    int                need;
    logic              hit;
    int                hk;
    logic [SW-1:0]     hrdy;
    logic [SW-1:0]     sel;
    logic [SW-1:0]     late;
    logic              stl;

    if (gi == 0) begin : rs1_g
      assign src  = rs1_ID;
      assign used = rs1use_ID;
      assign need = 0;
    end else begin : rs2_g
      assign src  = rs2_ID;
      assign used = rs2use_ID;
      assign need = rs2late_ID ? STORE_NEED : 0;
    end

    always_comb begin
      hit  = 1'b0;
      hk   = 0;
      hrdy = '0;
      // Scan oldest to youngest so the youngest matching producer is left in hk.
      for (int k = DEPTH; k >= 1; k--) begin
        if (v_reg[k] && wen_reg[k] && rd_reg[k] == src && src != '0) begin
          hit  = 1'b1;
          hk   = k;
          hrdy = rdy_reg[k];
        end
      end
      sel  = '0;
      late = '0;
      stl  = 1'b0;
      if (used && hit) begin
        if (int'(hrdy) <= hk) begin
          sel = SW'(hk);
        end else if (int'(hrdy) <= hk + need) begin
          // Late case implies hk < rdy <= DEPTH, so hk + need stays in range for STORE_NEED = 1.
          late = SW'(hk + need);
        end else begin
          stl = 1'b1;
        end
      end
    end
  end

  assign stall = valid_ID & (src_gen[0].stl | src_gen[1].stl);
  assign issue = valid_ID & ~stall;

  assign PC_EN_IF     = ~stall;
  assign reg_FD_EN    = ~stall;
  assign reg_DE_flush = stall;
  assign reg_FD_flush = branch_ID & ~stall;
  assign fwd_sel_A    = src_gen[0].sel;
  assign fwd_sel_B    = src_gen[1].sel;
  assign fwd_ls_sel   = v_reg[STORE_NEED] ? ls_reg[STORE_NEED] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= DEPTH; k++) begin
        v_reg[k]   <= 1'b0;
        rd_reg[k]  <= '0;
        wen_reg[k] <= 1'b0;
        rdy_reg[k] <= '0;
        ls_reg[k]  <= '0;
      end
    end else begin
      v_reg[1]   <= issue;
      rd_reg[1]  <= rd_ID;
      wen_reg[1] <= wen_ID;
      rdy_reg[1] <= rdy_stage_ID;
      ls_reg[1]  <= issue ? src_gen[1].late : '0;
      for (int k = 2; k <= DEPTH; k++) begin
        v_reg[k]   <= v_reg[k-1];
        rd_reg[k]  <= rd_reg[k-1];
        wen_reg[k] <= wen_reg[k-1];
        rdy_reg[k] <= rdy_reg[k-1];
        ls_reg[k]  <= ls_reg[k-1];
      end
    end
  end

`ifdef HDU_PERF_CNT_EN
  logic [31:0] stall_cnt_reg;
  logic [31:0] flush_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (stall && stall_cnt_reg != 32'hFFFF_FFFF) stall_cnt_reg <= stall_cnt_reg + 32'd1;
      if (reg_FD_flush && flush_cnt_reg != 32'hFFFF_FFFF) flush_cnt_reg <= flush_cnt_reg + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

  rdy_legal: assert property (@(posedge clk) disable iff (!rst_n)
    (valid_ID && wen_ID) |-> (rdy_stage_ID != '0 && int'(rdy_stage_ID) <= DEPTH));

endmodule

// File: doc/hazard_scoreboard_unit.md
Name: hazard_scoreboard_unit

Overview:
- Parametrised successor to the 5-stage hazard detection unit: stall, forwarding and flush control for an in-order pipeline of DEPTH post-ID stages (stage 1 = EX, 2 = MEM, ... DEPTH = WB).
- Keeps an internal shift-register scoreboard of in-flight producers. Each producer carries its own ready stage, so ALU, load and multi-stage (e.g. multiply) results are handled by one rule.
- Adds late-consumer support, e.g. store data needed in MEM, with tracked late forwarding.

Parameters:
DEPTH, 3, number of post-ID stages tracked; stage numbering 1..DEPTH
REG_AW, 5, register address width; register 0 is never a hazard
STORE_NEED, 1, stage offset at which a late rs2 consumer (store data) reads its operand
SW, $clog2(DEPTH+1), stage-select width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
valid_ID  in  1  ID holds a real instruction
branch_ID  in  1  taken branch/jump resolved in ID
rs1_ID, rs2_ID  in  REG_AW  source registers
rs1use_ID, rs2use_ID  in  1  source actually read
rs2late_ID  in  1  rs2 consumed STORE_NEED stages later (store data)
rd_ID  in  REG_AW  destination
wen_ID  in  1  instruction writes rd
rdy_stage_ID  in  SW  stage whose output first holds the result (1..DEPTH)
PC_EN_IF  out  1  PC update enable
reg_FD_EN  out  1  IF/ID enable
reg_FD_flush  out  1  IF/ID flush
reg_DE_flush  out  1  ID/EX bubble insert
fwd_sel_A, fwd_sel_B  out  SW  0 = register file, k = output of stage k
fwd_ls_sel  out  SW  late store-data forward source for the instruction now in stage STORE_NEED; 0 = none
stall_cnt, flush_cnt  out  32  performance counters (see Optional Feature)

Behaviour:
- Scoreboard entry e[k], k = 1..DEPTH: {v, rd, wen, rdy, ls_src}. Every clock: e[k+1] <= e[k]; e[DEPTH] drops off.
- e[1] <= ID info when issue = valid_ID & ~stall; otherwise e[1] <= bubble (v = 0).
- Per source s (rs1 need 0; rs2 need = rs2late_ID ? STORE_NEED : 0):
  - Match = smallest k with v & wen & rd == s & s != 0. The youngest producer wins.
  - No match: select 0.
  - rdy <= k: fwd_sel = k.
  - rdy <= k+need: no stall, fwd_sel = 0; issued entry records ls_src = k + need.
  - Otherwise: stall.
  - Unused source (use = 0): select 0, no stall.
- stall = valid_ID & (stall_rs1 | stall_rs2).
- Outputs:
  - PC_EN_IF = reg_FD_EN = ~stall.
  - reg_DE_flush = stall.
  - reg_FD_flush = branch_ID & ~stall. On simultaneous stall and branch, the stall wins and the branch re-resolves next cycle.
  - fwd_ls_sel = e[STORE_NEED].v ? e[STORE_NEED].ls_src : 0.
- Producer and consumer shift in lockstep, so the distance is invariant. Register-file write at stage DEPTH is write-first, so no match beyond DEPTH.
- Latency: stall/forward outputs are combinational from ID inputs plus scoreboard state; scoreboard updates on the next edge.
- Reset (async, rst_n low):
  - all v = 0, ls_src = 0;
  - outputs PC_EN_IF = 1, reg_FD_EN = 1, flushes 0, all selects 0, counters 0.
  - Reset asserted mid-stall clears all pending hazards immediately.
- rdy_stage_ID = 0 or > DEPTH is illegal; behaviour is undefined, and an assertion flags it in simulation.

Optional Feature:
- Macro HDU_PERF_CNT_EN.
- Defined: stall_cnt increments on each cycle with stall = 1, and flush_cnt on each cycle with reg_FD_flush = 1. Both saturate at 2^32-1 and reset to 0.
- Undefined: both outputs are tied to 0 and no counter flops exist.

Test Plan:
- ALU-ALU: x5 <= (rdy 1), next reads x5 as rs1 -> no stall, fwd_sel_A = 1; one bubble later -> fwd_sel_A = 2.
- Load-use: load x6 (rdy 2), next reads x6 -> stall one cycle (PC_EN_IF = 0, reg_DE_flush = 1); next cycle fwd_sel_A = 2; stall_cnt = 1 with macro.
- Load-store: load x7 (rdy 2), next store with rs2late = 1, rs2 = x7 -> no stall, fwd_sel_B = 0; one cycle later fwd_ls_sel = 2.
- Multi-stage: rdy 3 producer of x8 followed by reader -> exactly 2 stall cycles, then fwd_sel_A = 3; write to x0 with rdy 3 -> never stalls.
- Youngest wins: ALU x9 at stage 2 and ALU x9 at stage 1 -> fwd_sel_A = 1; stall coinciding with branch_ID -> reg_FD_flush = 0 that cycle, 1 the next.
- rst_n pulsed low during a load-use stall -> outputs return to reset values asynchronously; first instruction after release issues without stall.
